// File: rtl/oc8_pkg.sv
// Shared definitions for the oc8 front end.
// Opcode constants, fetch states and instruction length type.
package oc8_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_ADD_IMM = 8'h01;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    HOLD
  } fseq_state_e;

  typedef enum logic [1:0] {
    LEN1 = 2'd1,
    LEN2 = 2'd2,
    LEN3 = 2'd3
  } ilen_e;

endpackage

// File: rtl/opcode_len_decode.sv
// Combinational opcode decoder: byte length and illegal flag.
// Unknown opcodes are treated as 1-byte illegal instructions.
module opcode_len_decode
  import oc8_pkg::*;
(
  input  logic [7:0] opcode_i,
  output ilen_e      len_o,
  output logic       illegal_o
);

  always_comb begin
    len_o     = LEN1;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_LDA_IMM,
      OP_ADD_IMM: len_o = LEN2;
      OP_JMP_ABS: len_o = LEN3;
      OP_NOP:     len_o = LEN1;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch from a combinational ROM.
// Assembles 1-3 byte instructions and hands them off valid/ready.
module fetch_sequencer
  import oc8_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [15:0] instr_operand,
  output logic [15:0] instr_pc,
  output logic        instr_illegal,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  fseq_state_e state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic [15:0] ipc_q, ipc_d;
  logic        illegal_q, illegal_d;

  logic [7:0]  dec_op;
  ilen_e       dec_len;
  logic        dec_illegal;

  // Live byte in FETCH_OP, latched opcode afterwards.
  assign dec_op = (state_q == FETCH_OP) ? rom_data : opcode_q;

  opcode_len_decode u_dec (
    .opcode_i  (dec_op),
    .len_o     (dec_len),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;
    illegal_d = illegal_q;
    unique case (state_q)
      FETCH_OP: begin
        opcode_d  = rom_data;
        ipc_d     = pc_q;
        illegal_d = dec_illegal;
        operand_d = '0;
        pc_d      = pc_q + 16'd1;
        state_d   = (dec_len == LEN1) ? HOLD : FETCH_LO;
      end
      FETCH_LO: begin
        operand_d = {8'h00, rom_data};
        pc_d      = pc_q + 16'd1;
        state_d   = (dec_len == LEN2) ? HOLD : FETCH_HI;
      end
      FETCH_HI: begin
        operand_d[15:8] = rom_data;
        pc_d            = pc_q + 16'd1;
        state_d         = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          state_d = FETCH_OP;
          if (opcode_q == OP_JMP_ABS) pc_d = operand_q;
        end
      end
      default: state_d = FETCH_OP;
    endcase
    // Redirect wins over both sequential and jump targets.
    if (redirect_valid) begin
      state_d = FETCH_OP;
      pc_d    = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
      illegal_q <= illegal_d;
    end
  end

  assign rom_addr      = pc_q;
  assign instr_valid   = (state_q == HOLD);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;
  assign instr_illegal = illegal_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer.
// Directed ROM images; monitor checks every handshake transfer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [15:0] instr_pc;
  logic        instr_illegal;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opd;
    logic [15:0] pc;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rom_data = mem[rom_addr];

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_operand  (instr_operand),
    .instr_pc       (instr_pc),
    .instr_illegal  (instr_illegal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Monitor: one comparison per completed transfer.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL xfer_unexpected: got op=%h opd=%h pc=%h ill=%b",
                 instr_opcode, instr_operand, instr_pc, instr_illegal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (instr_opcode !== e.op || instr_operand !== e.opd ||
            instr_pc !== e.pc || instr_illegal !== e.ill) begin
          fails++;
          $display("FAIL xfer: got op=%h opd=%h pc=%h ill=%b want op=%h opd=%h pc=%h ill=%b",
                   instr_opcode, instr_operand, instr_pc, instr_illegal,
                   e.op, e.opd, e.pc, e.ill);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [15:0] opd,
                      input logic [15:0] pc, input logic ill);
    exp_t e;
    e.op = op; e.opd = opd; e.pc = pc; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic rst_assert();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic rst_release();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_base();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'hA9; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'h01;
    mem[4] = 8'h4C; mem[5] = 8'h02; mem[6] = 8'h00;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL timeout: got %0d pending want 0", sb.size());
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Straight-line program with ready held high.
    rst_assert();
    load_base();
    instr_ready = 1'b1;
    push(8'hA9, 16'h0000, 16'h0000, 1'b0);
    push(8'h01, 16'h0001, 16'h0002, 1'b0);
    push(8'h4C, 16'h0002, 16'h0004, 1'b0);
    rst_release();
    @(negedge clk);
    chk("first_addr", 32'(rom_addr), 32'h0000);
    chk("first_valid", 32'(instr_valid), 32'h0);
    wait_empty(40);
    @(negedge clk);
    chk("jmp_target_addr", 32'(rom_addr), 32'h0002);
    chk("jmp_target_valid", 32'(instr_valid), 32'h0);

    // Backpressure on the first instruction.
    rst_assert();
    load_base();
    instr_ready = 1'b0;
    push(8'hA9, 16'h0000, 16'h0000, 1'b0);
    rst_release();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    chk("stall_valid_seen", 32'(found), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_op", 32'(instr_opcode), 32'hA9);
      chk("stall_opd", 32'(instr_operand), 32'h0000);
      chk("stall_pc", 32'(instr_pc), 32'h0000);
      chk("stall_addr", 32'(rom_addr), 32'h0002);
    end
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_empty(10);

    // Redirect during FETCH_LO of the first instruction.
    rst_assert();
    load_base();
    push(8'h4C, 16'h0002, 16'h0004, 1'b0);
    rst_release();
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0004;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid_low", 32'(instr_valid), 32'h0);
    chk("redir_addr", 32'(rom_addr), 32'h0004);
    wait_empty(20);

    // Redirect coincident with the JMP transfer.
    rst_assert();
    load_base();
    push(8'hA9, 16'h0000, 16'h0000, 1'b0);
    push(8'h01, 16'h0001, 16'h0002, 1'b0);
    push(8'h4C, 16'h0002, 16'h0004, 1'b0);
    push(8'hA9, 16'h0000, 16'h0000, 1'b0);
    rst_release();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (instr_valid && instr_opcode == 8'h4C) found = 1'b1;
    end
    chk("jmp_seen", 32'(found), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("coinc_addr", 32'(rom_addr), 32'h0000);
    chk("coinc_valid", 32'(instr_valid), 32'h0);
    chk("jmp_counted_once", 32'(sb.size()), 32'h1);
    wait_empty(20);

    // Illegal opcode is a 1-byte instruction.
    rst_assert();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'hFF;
    mem[1] = 8'hEA;
    push(8'hFF, 16'h0000, 16'h0000, 1'b1);
    rst_release();
    wait_empty(10);
    @(negedge clk);
    chk("illegal_next_addr", 32'(rom_addr), 32'h0001);
    chk("illegal_next_valid", 32'(instr_valid), 32'h0);

    // Reset in the middle of FETCH_HI.
    rst_assert();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h4C; mem[1] = 8'h34; mem[2] = 8'h12;
    rst_release();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_op", 32'(instr_opcode), 32'h4C);
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_op", 32'(instr_opcode), 32'h00);
    chk("rst_opd", 32'(instr_operand), 32'h0000);
    chk("rst_pc", 32'(instr_pc), 32'h0000);
    chk("rst_ill", 32'(instr_illegal), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0000);

    // Reset while fetching from FFFF.
    mem[16'hFFFF] = 8'h4C;
    mem[0] = 8'h78;
    mem[1] = 8'h56;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("ffff_addr", 32'(rom_addr), 32'hFFFF);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ffff_rst_addr", 32'(rom_addr), 32'h0000);
    chk("ffff_rst_valid", 32'(instr_valid), 32'h0);

    // 3-byte instruction straddling the address wrap.
    push(8'h4C, 16'h5678, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_op_addr", 32'(rom_addr), 32'hFFFF);
    @(negedge clk);
    chk("wrap_lo_addr", 32'(rom_addr), 32'h0000);
    @(negedge clk);
    chk("wrap_hi_addr", 32'(rom_addr), 32'h0001);
    wait_empty(10);
    @(negedge clk);
    chk("wrap_jmp_addr", 32'(rom_addr), 32'h5678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the address of the first opcode fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port rom_addr, output, 16, the program ROM byte address (combinational-read ROM).
REQ-005 SHALL have port rom_data, input, 8, the ROM byte at rom_addr, valid in the same cycle.
REQ-006 SHALL have port instr_valid, output, 1, a complete instruction is presented.
REQ-007 SHALL have port instr_ready, input, 1, the consumer accepts; transfer occurs when valid and ready are both high at a rising edge.
REQ-008 SHALL have port instr_opcode, output, 8, the opcode byte.
REQ-009 SHALL have port instr_operand, output, 16, the operand as {hi,lo}; the unused high byte reads 0 for 2-byte instructions and the whole field reads 0 for 1-byte instructions.
REQ-010 SHALL have port instr_pc, output, 16, the address of the opcode byte.
REQ-011 SHALL have port instr_illegal, output, 1, high when the opcode is not in the decode table.
REQ-012 SHALL have port redirect_valid, input, 1, an external PC override request.
REQ-013 SHALL have port redirect_pc, input, 16, the override target address.

Function
REQ-014 SHALL decode instruction length as: 8'hA9 (LDA #imm) 2 bytes, 8'h01 (ADD #imm) 2 bytes, 8'h4C (JMP abs, lo then hi) 3 bytes, 8'hEA (NOP) 1 byte, any other opcode 1 byte with instr_illegal=1.
REQ-015 SHALL implement states FETCH_OP, FETCH_LO, FETCH_HI, HOLD.
REQ-016 SHALL drive rom_addr from the internal pc register in every state, and pc SHALL increment by 1 on each byte captured, wrapping from 16'hFFFF to 16'h0000.
REQ-017 In FETCH_OP, SHALL capture the opcode and instr_pc, then go to HOLD for length 1 and to FETCH_LO otherwise.
REQ-018 In FETCH_LO, SHALL capture the low operand byte, then go to HOLD for length 2 and to FETCH_HI for length 3.
REQ-019 In FETCH_HI, SHALL capture the high operand byte and go to HOLD.
REQ-020 In HOLD, SHALL assert instr_valid with stable outputs until transfer, then go to FETCH_OP.
REQ-021 On transfer of JMP, SHALL load pc with instr_operand instead of the sequential address.
REQ-022 SHALL have these latencies, with ROM data present: a 1-byte instruction is valid 1 cycle after its opcode fetch, a 2-byte instruction 2 cycles after, a 3-byte instruction 3 cycles after.
REQ-023 SHALL give a sustained throughput of one instruction per (length+1) cycles when instr_ready is held high.
REQ-024 On redirect_valid in any state, SHALL discard any partial or held instruction, load pc with redirect_pc, enter FETCH_OP, and hold instr_valid low the next cycle.
REQ-025 When redirect coincides with a transfer, SHALL count the transfer as completed and let redirect_pc override the JMP target or sequential pc.
REQ-026 SHALL NOT change instr_opcode, instr_operand, instr_pc or instr_illegal while instr_valid is high and instr_ready is low.

Reset
REQ-027 When rst_n is low at a rising edge, SHALL set state=FETCH_OP, pc=RESET_PC, instr_valid=0, and instr_opcode, instr_operand, instr_pc and instr_illegal to 0, regardless of current state or pending redirect.
REQ-028 When reset is released, SHALL present rom_addr=RESET_PC in the first cycle.

Structure
REQ-029 SHALL place the opcode constants (OP_LDA_IMM, OP_ADD_IMM, OP_JMP_ABS, OP_NOP), the state enum and the length type in shared package oc8_pkg.
REQ-030 SHALL use one sub-module, opcode_len_decode, a combinational opcode to {length, illegal} decoder reused by later decode stages.

Verification
REQ-031 The bench SHALL use a ROM holding A9 00 01 01 4C 02 00 at address 0 with instr_ready=1, and SHALL check three transfers: (A9, 0000, pc 0000), (01, 0001, pc 0002), (4C, 0002, pc 0004); the next fetch SHALL use rom_addr=0002.
REQ-032 The bench SHALL hold instr_ready=0 for 5 cycles on the first instruction and SHALL check that instr_valid stays high, outputs stay stable and rom_addr stays at 0002.
REQ-033 The bench SHALL pulse redirect_valid with redirect_pc=0004 during FETCH_LO of the first instruction, and SHALL check that no instruction at pc 0000 is emitted and that the next transfer is 4C at pc 0004.
REQ-034 The bench SHALL assert redirect (redirect_pc=0000) in the same cycle as the JMP transfer, and SHALL check that the JMP is counted once and the next opcode is fetched from 0000, not 0002.
REQ-035 The bench SHALL place byte FF at address 0, and SHALL check one 1-byte transfer with instr_illegal=1 followed by a fetch from 0001.
REQ-036 The bench SHALL assert rst_n=0 mid-FETCH_HI and at address FFFF, and SHALL check the reset values and that a 3-byte instruction straddling FFFF wraps its operand fetch to 0000/0001.
